conv_enc_tx: RTL

Rate-1/2, constraint-length-3 convolutional encoder on the transmit side of the Viterbi link. It produces the 2-bit symbol pairs that the decoder's branch-metric units compare against, with each pair's bit 1 / bit 0 order matching the decoder's `rx_pair`. Per frame it accepts a stream of data bits under a valid/ready handshake and emits one registered symbol pair per bit. At frame end it appends two zero tail bits so the trellis terminates in state 00, and flags the final symbol.

---
 rtl/conv_enc_tx.sv | 114 +++++++++++
 1 files changed

// File: rtl/conv_enc_tx.sv
// Rate-1/2, K=3 convolutional encoder with zero-tail frame termination.
// Emits one registered symbol pair per accepted bit, plus two tail symbols per frame.
module conv_enc_tx #(
  parameter logic [2:0]  G0    = 3'b111,
  parameter logic [2:0]  G1    = 3'b101,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             in_ready,
  output logic             enc_valid,
  output logic [1:0]       enc_pair,
  output logic             enc_last,
  input  logic             out_ready,
  output logic [CNT_W-1:0] sym_count
);

  typedef enum logic [1:0] {RUN, TAIL1, TAIL2} state_e;

  state_e             state_q, state_d;
  logic [1:0]         s_q, s_d;
  logic [1:0]         enc_pair_q, enc_pair_d;
  logic               enc_valid_q, enc_valid_d;
  logic               enc_last_q, enc_last_d;
  logic [CNT_W-1:0]   sym_count_q, sym_count_d;

  logic               slot_free;
  logic               gen;
  logic               gen_last;
  logic               b;
  logic [2:0]         taps;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    enc_pair_d  = enc_pair_q;
    enc_valid_d = enc_valid_q;
    enc_last_d  = enc_last_q;
    sym_count_d = sym_count_q;
    in_ready    = 1'b0;
    gen         = 1'b0;
    gen_last    = 1'b0;
    b           = 1'b0;
    slot_free   = !enc_valid_q || out_ready;

    unique case (state_q)
      RUN: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          gen = 1'b1;
          b   = in_bit;
          if (in_last) state_d = TAIL1;
        end
      end
      TAIL1: begin
        if (slot_free) begin
          gen     = 1'b1;
          state_d = TAIL2;
        end
      end
      TAIL2: begin
        if (slot_free) begin
          gen      = 1'b1;
          gen_last = 1'b1;
          state_d  = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // Drain first, then let a newly generated symbol overwrite the slot.
    if (enc_valid_q && out_ready) begin
      enc_valid_d = 1'b0;
      enc_last_d  = 1'b0;
      if (enc_last_q) sym_count_d = '0;
      else            sym_count_d = sym_count_q + CNT_W'(1);
    end

    taps = {b, s_q[0], s_q[1]};
    if (gen) begin
      enc_pair_d  = {^(G0 & taps), ^(G1 & taps)};
      s_d         = {s_q[0], b};
      enc_valid_d = 1'b1;
      enc_last_d  = gen_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      s_q         <= '0;
      enc_pair_q  <= '0;
      enc_valid_q <= 1'b0;
      enc_last_q  <= 1'b0;
      sym_count_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      enc_pair_q  <= enc_pair_d;
      enc_valid_q <= enc_valid_d;
      enc_last_q  <= enc_last_d;
      sym_count_q <= sym_count_d;
    end
  end

  assign enc_valid = enc_valid_q;
  assign enc_pair  = enc_pair_q;
  assign enc_last  = enc_last_q;
  assign sym_count = sym_count_q;

endmodule
